i2s_capture: RTL and testbench

Receive-side counterpart of the audio DAC serializer. It drives the master, serial and LR clocks to the Pmod I2S2 ADC and deserializes its `sdout` stream into 16-bit left and right samples. Each completed stereo frame is handed downstream through a valid/ready holding register. A decaying peak meter on the left channel feeds the LED bar.

---
 rtl/audio_pkg.sv | 16 +
 rtl/i2s_capture_peak_meter.sv | 48 ++++
 rtl/i2s_capture.sv | 102 ++++++++++
 tb/tb_i2s_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared I2S frame definitions for the Pmod I2S2 capture and playback paths.
// Slot constants describe where each sample bit sits in a 32-slot stereo frame.
package audio_pkg;

  localparam int         FRAME_CNT_W   = 9;
  localparam int         SLOT_LSB      = 4;
  localparam logic [3:0] CAPTURE_PHASE = 4'hA;

  typedef logic signed [15:0] sample_t;

  // I2S one-bit delay: slot 0 carries the previous right LSB, left MSB is in slot 1
  localparam logic [4:0] FRAME_END_SLOT = 5'd0;
  localparam logic [4:0] LEFT_MSB_SLOT  = 5'd1;
  localparam logic [4:0] RIGHT_MSB_SLOT = 5'd17;

endpackage

// File: rtl/i2s_capture_peak_meter.sv
// Decaying peak detector on a signed sample stream; the top four bits of the
// 15-bit peak drive the LED bar.
module peak_meter
  import audio_pkg::*;
#(
  parameter int DECAY_SH = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld_p0,
  input  logic [15:0] sample_p0,
  output logic [3:0]  level
);

  function automatic logic [14:0] sat_mag(input sample_t x);
    sample_t neg;
    if (x[15] && (x[14:0] == 15'd0)) return 15'h7FFF;
    neg = -x;
    return (x < 0) ? neg[14:0] : x[14:0];
  endfunction

  function automatic logic [14:0] decay(input logic [14:0] p);
    return p - (p >> DECAY_SH);
  endfunction

  logic [14:0] mag_p1;
  logic        vld_p1;
  logic [14:0] peak;

  // p0 -> p1: magnitude
  always_ff @(posedge clk) begin
    mag_p1 <= sat_mag($signed(sample_p0));
  end

  // p1 -> p2: peak hold with decay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      peak   <= 15'd0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p1) peak <= (mag_p1 > peak) ? mag_p1 : decay(peak);
    end
  end

  assign level = peak[14:11];

endmodule

// File: rtl/i2s_capture.sv
// Pmod I2S2 ADC receiver: generates mclk/sck/lrck from a frame counter,
// deserializes sdout into stereo samples behind a valid/ready holding register.
module i2s_capture
  import audio_pkg::*;
#(
  parameter int CNT_W    = FRAME_CNT_W,
  parameter int DECAY_SH = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_sdout,
  output logic        adc_mclk,
  output logic        adc_sck,
  output logic        adc_lrck,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic [3:0]  level
);

  logic [CNT_W-1:0] cnt;
  logic             sd_q;
  logic [15:0]      sh_left;
  logic [14:0]      sh_right;
  logic             primed;
  logic [4:0]       slot;
  logic             capture;
  logic             complete;
  logic             load;

  assign adc_mclk = cnt[1];
  assign adc_sck  = cnt[3];
  assign adc_lrck = cnt[CNT_W-1];

  assign slot     = cnt[SLOT_LSB +: 5];
  assign capture  = en && (cnt[3:0] == CAPTURE_PHASE);
  assign complete = capture && (slot == FRAME_END_SLOT);
  // the first completion after start-up only closes a partial frame
  assign load     = complete && primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sd_q     <= 1'b0;
      sh_left  <= '0;
      sh_right <= '0;
      primed   <= 1'b0;
    end else begin
      sd_q <= adc_sdout;
      if (!en) begin
        cnt      <= '0;
        sh_left  <= '0;
        sh_right <= '0;
        primed   <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        if (capture) begin
          if (slot >= LEFT_MSB_SLOT && slot < RIGHT_MSB_SLOT)
            sh_left <= {sh_left[14:0], sd_q};
          else
            sh_right <= {sh_right[13:0], sd_q};
        end
        if (complete) primed <= 1'b1;
      end
    end
  end

  // Holding register; an overrun set outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        sample_left  <= sh_left;
        sample_right <= {sh_right, sd_q};
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (load && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  peak_meter #(
    .DECAY_SH (DECAY_SH)
  ) u_peak (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_p0    (load),
    .sample_p0 (sh_left),
    .level     (level)
  );

endmodule

// File: tb/tb_i2s_capture.sv
// Bench for i2s_capture: an I2S ADC model feeds stereo words, a scoreboard
// predicts every loaded frame and the left-channel peak.
module tb_i2s_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        adc_sdout = 1'b0;
  logic        adc_mclk, adc_sck, adc_lrck;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overrun;
  logic        overrun_clr = 1'b0;
  logic [3:0]  level;

  i2s_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .adc_sdout    (adc_sdout),
    .adc_mclk     (adc_mclk),
    .adc_sck      (adc_sck),
    .adc_lrck     (adc_lrck),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .level        (level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Frame position as the ADC sees it
  logic [8:0]  tb_cnt = 9'd0;
  logic [31:0] cur_word = 32'd0;
  logic [15:0] stim_l = 16'h0000;
  logic [15:0] stim_r = 16'h0000;
  logic [31:0] sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 9'd0;
    else if (!en) tb_cnt <= 9'd0;
    else tb_cnt <= tb_cnt + 9'd1;
  end

  // New word starts at slot 1; slot 0 still carries the previous word's right LSB
  always @(posedge clk) begin
    if (!en) sb.delete();
    else if (rst_n && tb_cnt == 9'h00F) begin
      cur_word <= {stim_l, stim_r};
      sb.push_back({stim_l, stim_r});
    end
  end

  always @(negedge clk) begin
    int s;
    s = int'(tb_cnt[8:4]);
    adc_sdout = (s == 0) ? cur_word[0] : cur_word[32 - s];
  end

  function automatic int mag_of(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return x;
  endfunction

  int          pk = 0;
  bit          pk_due = 1'b0;
  logic [31:0] mon_w;
  int          mon_m;

  always @(negedge clk) begin
    if (rst_n && en) begin
      if (tb_cnt == 9'h00B && sb.size() > 0) begin
        mon_w = sb.pop_front();
        chk("mon_valid", 32'(sample_valid), 32'd1);
        chk("mon_left", 32'(sample_left), 32'(mon_w[31:16]));
        chk("mon_right", 32'(sample_right), 32'(mon_w[15:0]));
        mon_m = mag_of(mon_w[31:16]);
        if (mon_m > pk) pk = mon_m;
        else pk = pk - (pk >>> 6);
        pk_due = 1'b1;
      end else if (tb_cnt == 9'h00C && pk_due) begin
        pk_due = 1'b0;
        chk("mon_peak", 32'(dut.u_peak.peak), 32'(pk));
        chk("mon_level", 32'(level), 32'((pk >>> 11) & 15));
      end
    end
  end

  task automatic wait_cnt(input logic [8:0] c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != c && n < 1100);
    if (tb_cnt != c) chk("wait_timeout", 32'(tb_cnt), 32'(c));
  endtask

  initial begin
    int errs;
    int vh;

    en = 1'b1;
    sample_ready = 1'b1;
    stim_l = 16'h1234;
    stim_r = 16'hA5C3;
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_left", 32'(sample_left), 32'd0);
    chk("rst_right", 32'(sample_right), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_clocks", 32'({adc_mclk, adc_sck, adc_lrck}), 32'd0);
    rst_n = 1'b1;

    errs = 0;
    vh = 0;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      if (adc_mclk !== tb_cnt[1] || adc_sck !== tb_cnt[3] || adc_lrck !== tb_cnt[8]) errs++;
      if (sample_valid) vh++;
    end
    chk("clock_phase", 32'(errs), 32'd0);
    chk("discard_first", 32'(vh), 32'd0);

    wait_cnt(9'h00A);
    chk("pre_valid", 32'(sample_valid), 32'd0);
    wait_cnt(9'h00B);
    chk("valid_rise", 32'(sample_valid), 32'd1);
    vh = 0;
    repeat (1024) begin
      @(negedge clk);
      if (sample_valid) vh++;
    end
    chk("pulse_per_frame", 32'(vh), 32'd2);

    // overrun: two frames with nothing consumed
    wait_cnt(9'h00C);
    sample_ready = 1'b0;
    stim_l = 16'h7ABC;
    stim_r = 16'h0F0F;
    wait_cnt(9'h00B);
    chk("ovr_first_load", 32'(overrun), 32'd0);
    stim_l = 16'h0001;
    wait_cnt(9'h00B);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_left", 32'(sample_left), 32'h0001);
    wait_cnt(9'h00A);
    overrun_clr = 1'b1;
    wait_cnt(9'h00B);
    overrun_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    stim_l = 16'h4321;
    stim_r = 16'h8765;
    wait_cnt(9'h040);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // accept in the completion cycle itself
    wait_cnt(9'h00A);
    sample_ready = 1'b1;
    wait_cnt(9'h00B);
    sample_ready = 1'b0;
    chk("same_cyc_valid", 32'(sample_valid), 32'd1);
    chk("same_cyc_ovr", 32'(overrun), 32'd0);
    chk("same_cyc_left", 32'(sample_left), 32'h4321);

    // peak meter: full-scale negative then silence
    stim_l = 16'h8000;
    stim_r = 16'h0000;
    wait_cnt(9'h010);
    stim_l = 16'h0000;
    wait_cnt(9'h00C);
    chk("peak_sat", 32'(dut.u_peak.peak), 32'd32767);
    chk("level_full", 32'(level), 32'hF);
    wait_cnt(9'h00C);
    chk("peak_decay1", 32'(dut.u_peak.peak), 32'd32256);
    repeat (4) wait_cnt(9'h00C);

    // enable drop mid-frame
    stim_l = 16'h5A5A;
    stim_r = 16'hC3C3;
    wait_cnt(9'h0C0);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_low_clocks", 32'({adc_mclk, adc_sck, adc_lrck}), 32'd0);
    chk("en_low_valid", 32'(sample_valid), 32'd1);
    chk("en_low_left", 32'(sample_left), 32'h0000);
    en = 1'b1;
    @(negedge clk);
    chk("en_restart_c1", 32'(adc_mclk), 32'd0);
    @(negedge clk);
    chk("en_restart_c2", 32'(adc_mclk), 32'd1);
    wait_cnt(9'h00B);
    chk("en_discard_left", 32'(sample_left), 32'h0000);
    chk("en_discard_valid", 32'(sample_valid), 32'd1);
    wait_cnt(9'h00B);
    chk("en_reload_left", 32'(sample_left), 32'h5A5A);
    chk("en_reload_right", 32'(sample_right), 32'hC3C3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
